// File: rtl/bin_to_seg_display_if.sv
// Request/result bundle for the binary-to-seven-segment converter.
// The requester drives start/din/is_signed; the converter returns status, BCD and segment patterns.
interface bin_to_seg_display_if;
  logic        start;
  logic [7:0]  din;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg_sign;
  logic [6:0]  seg_hund;
  logic [6:0]  seg_tens;
  logic [6:0]  seg_ones;

  modport master (
    output start, din, is_signed,
    input  busy, done, bcd, seg_sign, seg_hund, seg_tens, seg_ones
  );

  modport slave (
    input  start, din, is_signed,
    output busy, done, bcd, seg_sign, seg_hund, seg_tens, seg_ones
  );
endinterface

// File: rtl/bin_to_seg_display.sv
// Sequential double-dabble converter: turns an 8-bit signed/unsigned value into
// BCD and four active-low seven-segment patterns (sign, hundreds, tens, ones).
module bin_to_seg_display (
  input  logic                  clk,
  input  logic                  reset,
  bin_to_seg_display_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  state_t      state;
  state_t      state_next;
  logic [2:0]  iter;
  logic        neg;
  logic [7:0]  mag;
  logic [11:0] work;
  logic [11:0] work_adj;
  logic        done_r;
  logic [11:0] bcd_r;
  logic [6:0]  seg_sign_r;
  logic [6:0]  seg_hund_r;
  logic [6:0]  seg_tens_r;
  logic [6:0]  seg_ones_r;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (iter == 3'd7) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign work_adj = {dabble(work[11:8]), dabble(work[7:4]), dabble(work[3:0])};

  // The magnitude never exceeds 255 (128 when signed), so an 8-bit shift
  // register and exactly eight dabble iterations cover every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter       <= 3'd0;
      neg        <= 1'b0;
      mag        <= 8'd0;
      work       <= 12'd0;
      done_r     <= 1'b0;
      bcd_r      <= 12'h000;
      seg_sign_r <= SEG_BLANK;
      seg_hund_r <= SEG_BLANK;
      seg_tens_r <= SEG_BLANK;
      seg_ones_r <= SEG_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg  <= bus.is_signed & bus.din[7];
            mag  <= (bus.is_signed & bus.din[7]) ? (~bus.din + 8'd1) : bus.din;
            work <= 12'd0;
            iter <= 3'd0;
          end
        end
        SHIFT: begin
          {work, mag} <= {work_adj[10:0], mag, 1'b0};
          iter        <= iter + 3'd1;
        end
        COMMIT: begin
          done_r     <= 1'b1;
          bcd_r      <= work;
          seg_sign_r <= neg ? SEG_MINUS : SEG_BLANK;
          seg_hund_r <= (work[11:8] == 4'd0) ? SEG_BLANK : digit_seg(work[11:8]);
          seg_tens_r <= (work[11:4] == 8'd0) ? SEG_BLANK : digit_seg(work[7:4]);
          seg_ones_r <= digit_seg(work[3:0]);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.bcd      = bcd_r;
  assign bus.seg_sign = seg_sign_r;
  assign bus.seg_hund = seg_hund_r;
  assign bus.seg_tens = seg_tens_r;
  assign bus.seg_ones = seg_ones_r;

endmodule

// File: tb/tb_bin_to_seg_display.sv
// Bench for bin_to_seg_display: a decimal-arithmetic model tracks every cycle,
// plus literal expectations for the documented example conversions.
module tb_bin_to_seg_display;

  logic clk = 1'b0;
  logic reset;

  bin_to_seg_display_if bus();

  bin_to_seg_display dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit chk_en    = 1'b0;

  int          remain = 0;
  logic        exp_done = 1'b0;
  logic [11:0] exp_bcd,  pend_bcd;
  logic [6:0]  exp_sign, pend_sign;
  logic [6:0]  exp_hund, pend_hund;
  logic [6:0]  exp_tens, pend_tens;
  logic [6:0]  exp_ones, pend_ones;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_result(input logic [7:0] d, input logic s,
                              output logic [11:0] b, output logic [6:0] sg,
                              output logic [6:0] hd, output logic [6:0] tn,
                              output logic [6:0] on);
    int  m, h, t, o;
    bit  n;
    n  = s && d[7];
    m  = n ? 256 - int'(d) : int'(d);
    h  = m / 100;
    t  = (m / 10) % 10;
    o  = m % 10;
    b  = {4'(h), 4'(t), 4'(o)};
    sg = n ? 7'h3F : 7'h7F;
    hd = (h == 0) ? 7'h7F : seg_of(h);
    tn = (h == 0 && t == 0) ? 7'h7F : seg_of(t);
    on = seg_of(o);
  endtask

  // Model: a request is accepted only when nothing is pending, and its
  // result appears nine edges later.
  always @(posedge clk) begin
    exp_done = 1'b0;
    if (reset) begin
      remain   = 0;
      exp_bcd  = 12'h000;
      exp_sign = 7'h7F;
      exp_hund = 7'h7F;
      exp_tens = 7'h7F;
      exp_ones = 7'h40;
    end else if (remain > 0) begin
      remain--;
      if (remain == 0) begin
        exp_bcd  = pend_bcd;
        exp_sign = pend_sign;
        exp_hund = pend_hund;
        exp_tens = pend_tens;
        exp_ones = pend_ones;
        exp_done = 1'b1;
      end
    end else if (bus.start) begin
      model_result(bus.din, bus.is_signed, pend_bcd, pend_sign, pend_hund, pend_tens, pend_ones);
      remain = 9;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",     32'(bus.busy),     32'(remain > 0));
      checkOutput("done",     32'(bus.done),     32'(exp_done));
      checkOutput("bcd",      32'(bus.bcd),      32'(exp_bcd));
      checkOutput("seg_sign", 32'(bus.seg_sign), 32'(exp_sign));
      checkOutput("seg_hund", 32'(bus.seg_hund), 32'(exp_hund));
      checkOutput("seg_tens", 32'(bus.seg_tens), 32'(exp_tens));
      checkOutput("seg_ones", 32'(bus.seg_ones), 32'(exp_ones));
    end
  end

  // Caller sits at a falling edge; inputs are held for one cycle.
  task automatic applyStimulus(input logic st, input logic [7:0] d, input logic s);
    bus.start     = st;
    bus.din       = d;
    bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int c);
    c = 0;
    while (bus.done !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic runConv(input logic [7:0] d, input logic s);
    int c;
    applyStimulus(1'b1, d, s);
    waitDone(c);
    checkOutput("latency", 32'(c), 32'd9);
  endtask

  initial begin
    int c;
    int seen;
    bus.start     = 1'b0;
    bus.din       = 8'h00;
    bus.is_signed = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy),     32'h0);
    checkOutput("idle_bcd",  32'(bus.bcd),      32'h000);
    checkOutput("idle_ones", 32'(bus.seg_ones), 32'h40);
    checkOutput("idle_hund", 32'(bus.seg_hund), 32'h7F);

    runConv(8'hFF, 1'b0);
    checkOutput("ff_bcd",  32'(bus.bcd),      32'h255);
    checkOutput("ff_hund", 32'(bus.seg_hund), 32'h24);
    checkOutput("ff_tens", 32'(bus.seg_tens), 32'h12);
    checkOutput("ff_ones", 32'(bus.seg_ones), 32'h12);
    checkOutput("ff_sign", 32'(bus.seg_sign), 32'h7F);
    @(negedge clk);

    runConv(8'hF6, 1'b1);
    checkOutput("f6_bcd",  32'(bus.bcd),      32'h010);
    checkOutput("f6_sign", 32'(bus.seg_sign), 32'h3F);
    checkOutput("f6_hund", 32'(bus.seg_hund), 32'h7F);
    checkOutput("f6_tens", 32'(bus.seg_tens), 32'h79);
    checkOutput("f6_ones", 32'(bus.seg_ones), 32'h40);
    @(negedge clk);

    runConv(8'h80, 1'b1);
    checkOutput("m128_bcd",  32'(bus.bcd),      32'h128);
    checkOutput("m128_sign", 32'(bus.seg_sign), 32'h3F);
    @(negedge clk);

    runConv(8'h00, 1'b1);
    checkOutput("zero_sign", 32'(bus.seg_sign), 32'h7F);
    checkOutput("zero_tens", 32'(bus.seg_tens), 32'h7F);
    @(negedge clk);

    applyStimulus(1'b1, 8'h07, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 8'h63, 1'b0);
    waitDone(c);
    checkOutput("ignored_bcd",  32'(bus.bcd),  32'h007);
    checkOutput("ignored_done", 32'(bus.done), 32'h1);

    applyStimulus(1'b1, 8'h63, 1'b0);
    waitDone(c);
    checkOutput("backtoback_latency", 32'(c),            32'd9);
    checkOutput("backtoback_bcd",     32'(bus.bcd),      32'h099);
    checkOutput("backtoback_hund",    32'(bus.seg_hund), 32'h7F);
    checkOutput("backtoback_tens",    32'(bus.seg_tens), 32'h10);
    @(negedge clk);

    applyStimulus(1'b1, 8'hC8, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checkOutput("abort_no_done", 32'(seen),         32'd0);
    checkOutput("abort_bcd",     32'(bus.bcd),      32'h000);
    checkOutput("abort_ones",    32'(bus.seg_ones), 32'h40);
    checkOutput("abort_busy",    32'(bus.busy),     32'h0);

    runConv(8'hC8, 1'b0);
    checkOutput("c8_bcd",  32'(bus.bcd),      32'h200);
    checkOutput("c8_hund", 32'(bus.seg_hund), 32'h24);
    checkOutput("c8_tens", 32'(bus.seg_tens), 32'h40);
    @(negedge clk);

    // Random traffic: inputs wander while busy, starts land in any cycle
    // (including the done cycle), and an occasional reset aborts work.
    repeat (800) begin
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
    end
    reset = 1'b0;

    repeat (12) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
